// File: rtl/temp_avg_sequencer.sv
//==============================================================================
// Module      : temp_avg_sequencer
// Description : Snapshots the sensor readings and active flags, accumulates the
//               active readings one sensor per cycle, then divides the sum by the
//               active count with a restoring divider (one quotient bit per
//               cycle). Quotient, remainder and count feed the display stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module temp_avg_sequencer #(
  parameter int NR_SENSORS = 25,
  parameter int TEMP_W     = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [NR_SENSORS*TEMP_W-1:0] sensors_temp_i,
  input  logic [NR_SENSORS-1:0]        sensors_active_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [15:0]                  temp_Q_o,
  output logic [15:0]                  temp_R_o,
  output logic [7:0]                   active_sensors_nr_o,
  output logic                         no_sensor_o
);

  localparam logic [7:0] LAST_IDX = 8'(NR_SENSORS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                         state_q;
  // Snapshots are consumed from the LSB end; shifting avoids a wide indexed mux.
  logic [NR_SENSORS*TEMP_W-1:0]   temps_q;
  logic [NR_SENSORS-1:0]          act_q;
  // sum_q is the accumulator in SCAN and the dividend/quotient register in DIV.
  logic [15:0]                    sum_q;
  logic [7:0]                     cnt_q;
  logic [7:0]                     idx_q;
  logic [15:0]                    rem_q;
  logic [3:0]                     bit_q;
  logic                           busy_q;
  logic                           done_q;
  logic [15:0]                    quo_out_q;
  logic [15:0]                    rem_out_q;
  logic [7:0]                     nr_out_q;
  logic                           nos_q;

  logic [15:0] temp_ext_d;
  logic [15:0] sum_d;
  logic [7:0]  cnt_d;
  logic [15:0] rem_sh_d;
  logic        rem_ge_d;
  logic [15:0] rem_d;
  logic [15:0] dvd_d;

  // Accumulate step for the current sensor and one restoring-division step.
  always_comb begin
    temp_ext_d = 16'(temps_q[TEMP_W-1:0]);
    sum_d      = act_q[0] ? (sum_q + temp_ext_d) : sum_q;
    cnt_d      = act_q[0] ? (cnt_q + 8'd1) : cnt_q;
    // Remainder is always below count (< 256), so the shifted value fits in 16 bits.
    rem_sh_d   = {rem_q[14:0], sum_q[15]};
    rem_ge_d   = (rem_sh_d >= {8'd0, cnt_q});
    rem_d      = rem_ge_d ? (rem_sh_d - {8'd0, cnt_q}) : rem_sh_d;
    dvd_d      = {sum_q[14:0], rem_ge_d};
  end

  // Sequencer FSM with registered result and status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      temps_q   <= '0;
      act_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      bit_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      nr_out_q  <= '0;
      nos_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            temps_q <= sensors_temp_i;
            act_q   <= sensors_active_i;
            sum_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          sum_q   <= sum_d;
          cnt_q   <= cnt_d;
          temps_q <= temps_q >> TEMP_W;
          act_q   <= act_q >> 1;
          idx_q   <= idx_q + 8'd1;
          if (idx_q == LAST_IDX) begin
            rem_q   <= '0;
            bit_q   <= '0;
            state_q <= (cnt_d != 8'd0) ? S_DIV : S_DONE;
          end
        end
        S_DIV: begin
          sum_q <= dvd_d;
          rem_q <= rem_d;
          bit_q <= bit_q + 4'd1;
          if (bit_q == 4'd15) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          if (cnt_q == 8'd0) begin
            quo_out_q <= '0;
            rem_out_q <= '0;
            nr_out_q  <= '0;
            nos_q     <= 1'b1;
          end else begin
            quo_out_q <= sum_q;
            rem_out_q <= rem_q;
            nr_out_q  <= cnt_q;
            nos_q     <= 1'b0;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign temp_Q_o            = quo_out_q;
  assign temp_R_o            = rem_out_q;
  assign active_sensors_nr_o = nr_out_q;
  assign no_sensor_o         = nos_q;

endmodule

`default_nettype wire

// File: tb/tb_temp_avg_sequencer.sv
//==============================================================================
// Module      : tb_temp_avg_sequencer
// Description : Directed and random stimulus for temp_avg_sequencer, checked
//               against hand-computed values and a behavioural mean model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_temp_avg_sequencer;

  localparam int NR = 25;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [NR*W-1:0] temps = '0;
  logic [NR-1:0]   act = '0;
  logic            busy_o;
  logic            done_o;
  logic [15:0]     temp_Q_o;
  logic [15:0]     temp_R_o;
  logic [7:0]      nr_o;
  logic            no_sensor_o;

  int n_tests = 0;
  int n_fail  = 0;

  temp_avg_sequencer #(.NR_SENSORS(NR), .TEMP_W(W)) u_dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .start_i             (start),
    .sensors_temp_i      (temps),
    .sensors_active_i    (act),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .temp_Q_o            (temp_Q_o),
    .temp_R_o            (temp_R_o),
    .active_sensors_nr_o (nr_o),
    .no_sensor_o         (no_sensor_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One complete run; optional disturbance pulses start and scrambles inputs mid-run.
  task automatic run(input string tag, input logic [NR*W-1:0] t, input logic [NR-1:0] a,
                     input bit disturb);
    int          sum = 0;
    int          cnt = 0;
    int          exp_lat;
    int          k;
    int          dones;
    int          busy_bad = 0;
    int          hold_bad = 0;
    logic [15:0] pq;
    logic [15:0] pr;
    logic [7:0]  pn;
    for (int i = 0; i < NR; i++) begin
      if (a[i]) begin
        sum += int'(t[i*W +: W]);
        cnt++;
      end
    end
    exp_lat = (cnt != 0) ? NR + 17 : NR + 1;
    pq = temp_Q_o; pr = temp_R_o; pn = nr_o;
    @(negedge clk);
    temps = t; act = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    if (disturb) begin
      temps = ~t;
      act   = ~a;
    end
    while (done_o !== 1'b1 && k < 200) begin
      if (busy_o !== 1'b1) busy_bad++;
      if (temp_Q_o !== pq || temp_R_o !== pr || nr_o !== pn) hold_bad++;
      @(negedge clk);
      k++;
      start = disturb && (k == 3 || k == 30 || k == 35);
    end
    start = 1'b0;
    dones = (done_o === 1'b1) ? 1 : 0;
    check({tag, " latency"}, k, exp_lat);
    check({tag, " busy_at_done"}, {31'd0, busy_o}, 0);
    check({tag, " Q"}, {16'd0, temp_Q_o}, (cnt != 0) ? sum / cnt : 0);
    check({tag, " R"}, {16'd0, temp_R_o}, (cnt != 0) ? sum % cnt : 0);
    check({tag, " nr"}, {24'd0, nr_o}, cnt);
    check({tag, " no_sensor"}, {31'd0, no_sensor_o}, (cnt == 0) ? 1 : 0);
    check({tag, " R<nr"}, {31'd0, (no_sensor_o == 1'b1) || (temp_R_o < {8'd0, nr_o})}, 1);
    check({tag, " busy_during_run"}, busy_bad, 0);
    check({tag, " outputs_hold"}, hold_bad, 0);
    repeat (disturb ? 45 : 2) begin
      @(negedge clk);
      if (done_o === 1'b1) dones++;
    end
    check({tag, " done_pulses"}, dones, 1);
  endtask

  initial begin
    logic [NR*W-1:0] t;
    logic [NR-1:0]   a;
    int              extra;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst busy", {31'd0, busy_o}, 0);
    check("rst done", {31'd0, done_o}, 0);
    check("rst Q", {16'd0, temp_Q_o}, 0);
    check("rst R", {16'd0, temp_R_o}, 0);
    check("rst nr", {24'd0, nr_o}, 0);
    check("rst no_sensor", {31'd0, no_sensor_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    // T1: all active, each 22
    for (int i = 0; i < NR; i++) t[i*W +: W] = 8'd22;
    run("T1", t, '1, 1'b0);

    // T2: sensors 0,7,24 active = 20,21,23; others 99 inactive
    for (int i = 0; i < NR; i++) t[i*W +: W] = 8'd99;
    t[0*W +: W] = 8'd20; t[7*W +: W] = 8'd21; t[24*W +: W] = 8'd23;
    a = '0; a[0] = 1'b1; a[7] = 1'b1; a[24] = 1'b1;
    run("T2", t, a, 1'b0);

    // T3: none active
    run("T3", t, '0, 1'b0);

    // T4: single max reading, then all max
    for (int i = 0; i < NR; i++) t[i*W +: W] = 8'd255;
    a = '0; a[5] = 1'b1;
    run("T4a", t, a, 1'b0);
    run("T4b", t, '1, 1'b0);

    // T5: start pulses and input changes mid-run
    for (int i = 0; i < NR; i++) t[i*W +: W] = 8'(i * 7 + 3);
    a = 25'h0_A5_3C_F1;
    run("T5", t, a, 1'b1);

    // T6: reset in the middle of DIV
    for (int i = 0; i < NR; i++) t[i*W +: W] = 8'd200;
    @(negedge clk);
    temps = t; act = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    check("T6 rst Q", {16'd0, temp_Q_o}, 0);
    check("T6 rst nr", {24'd0, nr_o}, 0);
    check("T6 rst busy", {31'd0, busy_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (50) begin
      @(negedge clk);
      if (done_o === 1'b1) extra++;
    end
    check("T6 no_done_after_rst", extra, 0);
    t = '0;
    for (int i = 0; i < NR; i++) t[i*W +: W] = 8'd99;
    t[0*W +: W] = 8'd20; t[7*W +: W] = 8'd21; t[24*W +: W] = 8'd23;
    a = '0; a[0] = 1'b1; a[7] = 1'b1; a[24] = 1'b1;
    run("T6 fresh", t, a, 1'b0);

    // Random masks and readings against the model
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NR; i++) t[i*W +: W] = 8'($urandom_range(0, 255));
      a = NR'($urandom);
      if (r == 0) a = NR'(1);
      run($sformatf("RND%0d", r), t, a, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
